// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between the host-side sweep configuration and dds_sweep_ctrl.
// MODE exists only when DDS_SWEEP_BIDIR_EN is defined.
interface dds_sweep_ctrl_if #(
  parameter int unsigned FW = 24,
  parameter int unsigned DW = 16
);
  logic          START;
  logic          ABORT;
  logic [FW-1:0] F_START;
  logic [FW-1:0] F_STOP;
  logic [FW-1:0] F_STEP;
  logic [DW-1:0] DWELL;
`ifdef DDS_SWEEP_BIDIR_EN
  logic          MODE;
`endif
  logic [FW-1:0] SET_FREQ;
  logic          ENB;
  logic          SAMPLE_VALID;
  logic          BUSY;
  logic          DONE;

  modport master (
`ifdef DDS_SWEEP_BIDIR_EN
    output MODE,
`endif
    output START, ABORT, F_START, F_STOP, F_STEP, DWELL,
    input  SET_FREQ, ENB, SAMPLE_VALID, BUSY, DONE
  );

  modport slave (
`ifdef DDS_SWEEP_BIDIR_EN
    input  MODE,
`endif
    input  START, ABORT, F_START, F_STOP, F_STEP, DWELL,
    output SET_FREQ, ENB, SAMPLE_VALID, BUSY, DONE
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Stepped-frequency sweep sequencer driving SET_FREQ/ENB of the DDS + Hilbert datapath.
// Defining DDS_SWEEP_BIDIR_EN adds MODE and a triangle (up then down) sweep.
module dds_sweep_ctrl #(
  parameter int unsigned FW     = 24,
  parameter int unsigned DW     = 16,
  parameter int unsigned SETTLE = 32
) (
  input logic             CLK,
  input logic             RST,
  dds_sweep_ctrl_if.slave bus
);

  localparam int unsigned SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam int unsigned CW = (DW > SW) ? DW : SW;
  localparam logic [CW-1:0] SettleLast = CW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StDwell, StDone} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [FW-1:0] stop_q, stop_d;
  logic [FW-1:0] step_q, step_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enb_q, enb_d;
  logic          sv_q, sv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [FW:0]   up_sum;
  logic [FW-1:0] up_next;
  logic          at_top;
  logic [DW-1:0] dwell_last;
  logic          finish;

`ifdef DDS_SWEEP_BIDIR_EN
  logic [FW-1:0] start_q, start_d;
  logic          mode_q, mode_d;
  logic          down_q, down_d;
  logic [FW:0]   dn_diff;
  logic [FW-1:0] dn_next;
`endif

  // Step arithmetic is one bit wider so the clamp catches overflow instead of wrapping.
  always_comb begin
    up_sum     = {1'b0, freq_q} + {1'b0, step_q};
    up_next    = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[FW-1:0];
    at_top     = (freq_q >= stop_q) || (step_q == '0);
    dwell_last = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
`ifdef DDS_SWEEP_BIDIR_EN
    dn_diff    = {1'b0, freq_q} - {1'b0, step_q};
    dn_next    = (dn_diff[FW] || (dn_diff[FW-1:0] < start_q)) ? start_q : dn_diff[FW-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    enb_d   = enb_q;
    sv_d    = sv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    finish  = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
    start_d = start_q;
    mode_d  = mode_q;
    down_d  = down_q;
`endif

    if (state_q != StIdle && bus.ABORT) begin
      state_d = StIdle;
      enb_d   = 1'b0;
      busy_d  = 1'b0;
      sv_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.START && !bus.ABORT) begin
            stop_d  = bus.F_STOP;
            step_d  = bus.F_STEP;
            dwell_d = bus.DWELL;
            freq_d  = bus.F_START;
            cnt_d   = '0;
            enb_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = StSettle;
`ifdef DDS_SWEEP_BIDIR_EN
            start_d = bus.F_START;
            mode_d  = bus.MODE;
            down_d  = 1'b0;
`endif
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_d   = '0;
            sv_d    = 1'b1;
            state_d = StDwell;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StDwell: begin
          if (cnt_q == CW'(dwell_last)) begin
            cnt_d = '0;
            sv_d  = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
            // Turn-around reuses the F_STOP point, so the first down point follows it directly.
            if (down_q) begin
              if (freq_q <= start_q) finish = 1'b1;
              else                   freq_d = dn_next;
            end else if (!at_top) begin
              freq_d = up_next;
            end else if (mode_q && (step_q != '0) && (freq_q > start_q)) begin
              freq_d = dn_next;
              down_d = 1'b1;
            end else begin
              finish = 1'b1;
            end
`else
            if (at_top) finish = 1'b1;
            else        freq_d = up_next;
`endif
            if (finish) begin
              done_d  = 1'b1;
              enb_d   = 1'b0;
              busy_d  = 1'b0;
              state_d = StDone;
            end else begin
              state_d = StSettle;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      freq_q  <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      enb_q   <= 1'b0;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      start_q <= '0;
      mode_q  <= 1'b0;
      down_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      enb_q   <= enb_d;
      sv_q    <= sv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DDS_SWEEP_BIDIR_EN
      start_q <= start_d;
      mode_q  <= mode_d;
      down_q  <= down_d;
`endif
    end
  end

  assign bus.SET_FREQ     = freq_q;
  assign bus.ENB          = enb_q;
  assign bus.SAMPLE_VALID = sv_q;
  assign bus.BUSY         = busy_q;
  assign bus.DONE         = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a point-list model feeds a queue, a monitor checks each
// dwell window and DONE pulse. Honours DDS_SWEEP_BIDIR_EN when defined.
module tb_dds_sweep_ctrl;
  localparam int unsigned FW     = 24;
  localparam int unsigned DW     = 16;
  localparam int unsigned SETTLE = 32;

  typedef enum int {EvPoint, EvAbort, EvDone} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [23:0] freq;
    int          dwell;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  exp_q[$];

  dds_sweep_ctrl_if #(.FW(FW), .DW(DW)) bus ();

  dds_sweep_ctrl #(.FW(FW), .DW(DW), .SETTLE(SETTLE)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input ev_kind_e k, input longint f, input int d);
    ev_t e;
    e.kind  = k;
    e.freq  = 24'(f);
    e.dwell = d;
    exp_q.push_back(e);
  endfunction

  // Reference: list every visited frequency, returns total cycles from START edge to DONE.
  function automatic int push_model(input longint lo, input longint hi, input longint s,
                                    input int dw, input bit md);
    longint f  = lo;
    int     d  = (dw == 0) ? 1 : dw;
    int     np = 1;
    push_ev(EvPoint, f, d);
    if (s != 0) begin
      while (f < hi) begin
        f = (f + s > hi) ? hi : f + s;
        push_ev(EvPoint, f, d);
        np++;
      end
      if (md) begin
        while (f > lo) begin
          f = (f - s < lo) ? lo : f - s;
          push_ev(EvPoint, f, d);
          np++;
        end
      end
    end
    push_ev(EvDone, f, 0);
    return np * (int'(SETTLE) + d);
  endfunction

  task automatic set_cfg(input longint st, input longint sp, input longint stp, input int dw,
                         input bit md);
    bus.F_START = 24'(st);
    bus.F_STOP  = 24'(sp);
    bus.F_STEP  = 24'(stp);
    bus.DWELL   = 16'(dw);
`ifdef DDS_SWEEP_BIDIR_EN
    bus.MODE    = md;
`else
    if (md) $display("note: MODE ignored in up-only build");
`endif
  endtask

  task automatic scramble();
    bus.F_START = 24'($urandom);
    bus.F_STOP  = 24'($urandom);
    bus.F_STEP  = 24'($urandom);
    bus.DWELL   = 16'($urandom);
  endtask

  task automatic start_sweep(input longint st, input longint sp, input longint stp,
                             input int dw, input bit md, output int exp_cyc);
    @(negedge clk);
    set_cfg(st, sp, stp, dw, md);
    bus.START = 1'b1;
    exp_cyc = push_model(st, sp, stp, dw, md);
  endtask

  // Drops START after the start edge, scrambles config, and times the DONE pulse.
  task automatic finish_sweep(input int exp_cyc);
    int n = 0;
    @(negedge clk);
    check("busy_after_start", bus.BUSY, 1);
    bus.START = 1'b0;
    scramble();
    while (!bus.DONE && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, exp_cyc);
    check("enb_at_done", bus.ENB, 0);
    check("busy_at_done", bus.BUSY, 0);
    @(negedge clk);
    check("done_one_cycle", bus.DONE, 0);
    check("enb_after_done", bus.ENB, 0);
    @(negedge clk);
  endtask

  initial begin : monitor
    bit          prev_sv    = 1'b0;
    int          settle_cnt = 0;
    int          run_len    = 0;
    logic [23:0] run_freq   = '0;
    ev_t         ev;
    int          act_kind;
    bit          exp_done;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sv    = 1'b0;
        settle_cnt = 0;
        run_len    = 0;
        continue;
      end
      if (bus.SAMPLE_VALID) begin
        check("enb_in_dwell", bus.ENB, 1);
        if (!prev_sv) begin
          check("settle_len", settle_cnt, SETTLE);
          run_freq = bus.SET_FREQ;
          run_len  = 1;
        end else begin
          run_len++;
          if (bus.SET_FREQ !== run_freq) check("freq_stable", bus.SET_FREQ, run_freq);
        end
        settle_cnt = 0;
      end else if (prev_sv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_point", run_freq, -1);
        end else begin
          ev = exp_q.pop_front();
          act_kind = (!bus.BUSY && !bus.DONE) ? EvAbort : EvPoint;
          check("end_kind", act_kind, ev.kind);
          check("point_freq", run_freq, ev.freq);
          if (ev.kind == EvPoint) check("dwell_len", run_len, ev.dwell);
          if (ev.kind == EvAbort) begin
            check("abort_enb", bus.ENB, 0);
            check("abort_freq_held", bus.SET_FREQ, ev.freq);
          end
        end
        exp_done = (exp_q.size() > 0) && (exp_q[0].kind == EvDone);
        check("done_pulse", bus.DONE, exp_done);
        if (exp_done) begin
          ev = exp_q.pop_front();
          check("done_freq_held", bus.SET_FREQ, ev.freq);
        end
      end else if (bus.DONE) begin
        check("stray_done", bus.DONE, 0);
      end
      if (!bus.SAMPLE_VALID) begin
        if (bus.BUSY) settle_cnt++;
        else          settle_cnt = 0;
      end
      prev_sv = bus.SAMPLE_VALID;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int exp_cyc;
    int n;
    int rises;
    bit prev;

    bus.START = 1'b1;
    bus.ABORT = 1'b0;
    set_cfg(40097, 43097, 1000, 4, 1'b0);

    // Reset held with START high: everything stays cleared.
    repeat (5) begin
      @(negedge clk);
      check("rst_set_freq", bus.SET_FREQ, 0);
      check("rst_enb", bus.ENB, 0);
      check("rst_sv", bus.SAMPLE_VALID, 0);
      check("rst_busy", bus.BUSY, 0);
      check("rst_done", bus.DONE, 0);
    end
    exp_cyc = push_model(40097, 43097, 1000, 4, 1'b0);
    check("plan2_total", exp_cyc, 144);
    rst_n = 1'b1;
    finish_sweep(exp_cyc);

    // Clamp at F_STOP, no-wrap near full scale, degenerate single-point configs.
    start_sweep(0, 2500, 1000, 1, 1'b0, exp_cyc);
    finish_sweep(exp_cyc);
    start_sweep(24'hFFF000, 24'hFFFFFF, 24'h800, 2, 1'b0, exp_cyc);
    finish_sweep(exp_cyc);
    start_sweep(7000, 9000, 0, 3, 1'b0, exp_cyc);
    finish_sweep(exp_cyc);
    start_sweep(5000, 100, 300, 2, 1'b0, exp_cyc);
    finish_sweep(exp_cyc);
    start_sweep(100, 100, 5, 0, 1'b0, exp_cyc);
    finish_sweep(exp_cyc);
`ifdef DDS_SWEEP_BIDIR_EN
    start_sweep(0, 2000, 1000, 2, 1'b1, exp_cyc);
    finish_sweep(exp_cyc);
    start_sweep(24'hFFF000, 24'hFFFFFF, 24'h900, 1, 1'b1, exp_cyc);
    finish_sweep(exp_cyc);
`endif

    // ABORT in the second point's dwell, with START also high.
    @(negedge clk);
    set_cfg(1000, 5000, 1000, 5, 1'b0);
    bus.START = 1'b1;
    push_ev(EvPoint, 1000, 5);
    push_ev(EvAbort, 2000, 0);
    @(negedge clk);
    bus.START = 1'b0;
    rises = 0;
    prev  = 1'b0;
    n     = 0;
    while (rises < 2 && n < 1000) begin
      if (bus.SAMPLE_VALID && !prev) rises++;
      prev = bus.SAMPLE_VALID;
      if (rises < 2) begin
        @(negedge clk);
        n++;
      end
    end
    check("reach_point2", rises, 2);
    bus.ABORT = 1'b1;
    bus.START = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.BUSY, 0);
    check("abort_enb", bus.ENB, 0);
    check("abort_sv", bus.SAMPLE_VALID, 0);
    check("abort_done", bus.DONE, 0);
    check("abort_freq", bus.SET_FREQ, 2000);
    @(negedge clk);
    check("abort_beats_start", bus.BUSY, 0);
    bus.ABORT = 1'b0;
    bus.START = 1'b0;
    start_sweep(1000, 5000, 1000, 5, 1'b0, exp_cyc);
    finish_sweep(exp_cyc);

    // START held through DONE: one idle cycle, then a fresh sweep.
    start_sweep(0, 2500, 1000, 1, 1'b0, exp_cyc);
    void'(push_model(0, 2500, 1000, 1, 1'b0));
    n = 0;
    @(negedge clk);
    while (!bus.DONE && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("restart_first_done", bus.DONE, 1);
    @(negedge clk);
    check("restart_idle_gap", bus.BUSY, 0);
    @(negedge clk);
    check("restart_busy", bus.BUSY, 1);
    bus.START = 1'b0;
    n = 0;
    while (!bus.DONE && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("restart_second_done", bus.DONE, 1);
    repeat (2) @(negedge clk);

    // Reset mid-sweep clears outputs at once with no DONE.
    @(negedge clk);
    set_cfg(10, 90, 20, 3, 1'b0);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_set_freq", bus.SET_FREQ, 0);
    check("midrst_enb", bus.ENB, 0);
    check("midrst_busy", bus.BUSY, 0);
    check("midrst_done", bus.DONE, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Randomised sweeps; config inputs are scrambled while each sweep runs.
    for (int i = 0; i < 24; i++) begin
      longint st, sp, stp;
      int     np, dw;
      bit     md;
      np  = $urandom_range(1, 5);
      stp = $urandom_range(1, 32'h000F_FFFF);
      st  = $urandom_range(0, 32'h00FF_FFFF);
      sp  = st + stp * (np - 1);
      if (np > 1) sp = sp - $urandom_range(0, 32'(stp - 1));
      if (sp > 'hFFFFFF) sp = 'hFFFFFF;
      case ($urandom_range(0, 7))
        0:       stp = 0;
        1:       sp  = (st > 0) ? st - 1 : 0;
        default: ;
      endcase
      dw = $urandom_range(0, 6);
      md = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      md = 1'($urandom_range(0, 1));
`endif
      start_sweep(st, sp, stp, dw, md, exp_cyc);
      finish_sweep(exp_cyc);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
